// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: bundles requester-side and timer-side signals of timer_arbiter.
// slave modport is the arbiter's view; master modport is the clients/timer side.
interface timer_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   REQ;
  logic [3*N_REQ-1:0] REQ_MIN;
  logic [6*N_REQ-1:0] REQ_SEC;
  logic [N_REQ-1:0]   GNT;
  logic [N_REQ-1:0]   DONE;
  logic               BUSY;
  logic               ERR;
  logic [2:0]         TMR_MIN;
  logic [5:0]         TMR_SEC;
  logic               TMR_START;
  logic               TMR_TIME_UP;

  modport slave (
    input  REQ, REQ_MIN, REQ_SEC, TMR_TIME_UP,
    output GNT, DONE, BUSY, ERR, TMR_MIN, TMR_SEC, TMR_START
  );

  modport master (
    output REQ, REQ_MIN, REQ_SEC, TMR_TIME_UP,
    input  GNT, DONE, BUSY, ERR, TMR_MIN, TMR_SEC, TMR_START
  );
endinterface

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one minute/second timer among N_REQ clients.
// Optional watchdog abort in RUN is enabled by defining TIMER_ARB_WATCHDOG_EN.
module timer_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WD_CYCLES = 512
) (
  input logic             SYSCLK,
  input logic             RST,
  timer_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned MIN_W   = 3;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned SEC_MAX = 59;

  // Parameter sanity: owner index width and watchdog counter range
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("timer_arbiter: N_REQ must be in 2..8");
  end
  if (WD_CYCLES < 1 || WD_CYCLES > 1024) begin : g_bad_wd
    $error("timer_arbiter: WD_CYCLES must fit the 10-bit watchdog counter");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [MIN_W-1:0]   tmr_min_q, tmr_min_d;
  logic [SEC_W-1:0]   tmr_sec_q, tmr_sec_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               found_c;
  logic [IDX_W-1:0]   pick_c;
  logic [MIN_W-1:0]   min_a [N_REQ];
  logic [SEC_W-1:0]   sec_a [N_REQ];
  logic [SEC_W-1:0]   sec_clamp_c;
  logic               preset_zero_c;
  logic               wd_hit_c;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef TIMER_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = 10;
  logic [WD_W-1:0] wd_cnt_q;

  // Watchdog counter: cleared in LOAD, counts RUN cycles
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      wd_cnt_q <= '0;
    end else if (state_q == LOAD) begin
      wd_cnt_q <= '0;
    end else if (state_q == RUN) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end

  // Limit is reached on the RUN cycle whose increment would hit WD_CYCLES
  assign wd_hit_c = (wd_cnt_q == WD_W'(WD_CYCLES - 1));
`else
  assign wd_hit_c = 1'b0;
`endif

  // Unpack per-requester presets
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      min_a[i] = bus.REQ_MIN[i*MIN_W +: MIN_W];
      sec_a[i] = bus.REQ_SEC[i*SEC_W +: SEC_W];
    end
  end

  // Round-robin search starting at the rotation pointer
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    pick_c  = '0;
    idx     = 0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      idx = (32'(ptr_q) + j) % N_REQ;
      if (!found_c && bus.REQ[IDX_W'(idx)]) begin
        found_c = 1'b1;
        pick_c  = IDX_W'(idx);
      end
    end
  end

  // Seconds above 59 would never match in the timer, so clamp them
  assign sec_clamp_c   = (sec_a[pick_c] > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : sec_a[pick_c];
  assign preset_zero_c = (tmr_min_q == '0) && (tmr_sec_q == '0);

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    tmr_min_d = tmr_min_q;
    tmr_sec_d = tmr_sec_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (found_c) begin
          owner_d   = pick_c;
          tmr_min_d = min_a[pick_c];
          tmr_sec_d = sec_clamp_c;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        state_d = preset_zero_c ? FIN : RUN;
      end
      RUN: begin
        if (bus.TMR_TIME_UP) begin
          state_d = FIN;
        end else if (wd_hit_c) begin
          state_d = FIN;
          err_d   = 1'b1;
        end
      end
      FIN: begin
        ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    gnt_d  = busy_d ? onehot(owner_d) : '0;
    done_d = (state_d == FIN) ? onehot(owner_d) : '0;
  end

  // State and output registers
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      tmr_min_q <= '0;
      tmr_sec_q <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      tmr_min_q <= tmr_min_d;
      tmr_sec_q <= tmr_sec_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.DONE      = done_q;
  assign bus.BUSY      = busy_q;
  assign bus.ERR       = err_q;
  assign bus.TMR_MIN   = tmr_min_q;
  assign bus.TMR_SEC   = tmr_sec_q;
  // Start is a decode of the LOAD state so it lasts exactly one cycle
  assign bus.TMR_START = (state_q == LOAD) && !preset_zero_c;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed + randomized bench with a transaction-level reference model.
module tb_timer_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned WD = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_arbiter_if #(.N_REQ(N)) bus();

  timer_arbiter #(.N_REQ(N), .WD_CYCLES(WD)) dut (
    .SYSCLK (clk),
    .RST    (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_ptr = 0;
  logic [2:0] m_min = '0;
  logic [5:0] m_sec = '0;
  logic [N-1:0] cur_req = '0;
  logic [2:0] pm [N];
  logic [5:0] ps [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    bus.REQ = cur_req;
    for (int i = 0; i < N; i++) begin
      bus.REQ_MIN[i*3 +: 3] = pm[i];
      bus.REQ_SEC[i*6 +: 6] = ps[i];
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  32'(bus.BUSY), 32'd0);
    check({tag, ".gnt"},   32'(bus.GNT), 32'd0);
    check({tag, ".done"},  32'(bus.DONE), 32'd0);
    check({tag, ".err"},   32'(bus.ERR), 32'd0);
    check({tag, ".start"}, 32'(bus.TMR_START), 32'd0);
    check({tag, ".min"},   32'(bus.TMR_MIN), 32'(m_min));
    check({tag, ".sec"},   32'(bus.TMR_SEC), 32'(m_sec));
  endtask

  // Called at the negedge of an IDLE cycle; steps to the negedge of the next cycle
  task automatic idle_cycle(input string tag);
    @(negedge clk);
    check_idle(tag);
  endtask

  // No requests for n cycles, optionally with a stray TIME_UP that must be ignored
  task automatic idle_gap(input int n, input bit spur);
    cur_req = '0;
    drive_inputs();
    bus.TMR_TIME_UP = spur;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle("gap");
    end
    bus.TMR_TIME_UP = 1'b0;
  endtask

  // One arbitration round. Starts at negedge of an IDLE cycle, ends at the negedge of FIN
  // (or at the reset point when abort_at is nonzero).
  task automatic run_txn(input logic [N-1:0] req, input bit drop, input bit spur, input int abort_at);
    int w, dur, fin_k;
    bit wd_abort;
    logic [N-1:0] oh;
    cur_req = req;
    drive_inputs();
    w = -1;
    for (int j = 0; j < N; j++) begin
      if (w < 0 && req[(m_ptr + j) % N]) w = (m_ptr + j) % N;
    end
    if (w < 0) begin
      check("txn.no_req", 32'(req), 32'hFFFF_FFFF);
      return;
    end
    oh    = '0;
    oh[w] = 1'b1;
    m_min = pm[w];
    m_sec = (ps[w] > 6'd59) ? 6'd59 : ps[w];
    dur   = int'(m_min) * 60 + int'(m_sec);
    wd_abort = 1'b0;
`ifdef TIMER_ARB_WATCHDOG_EN
    if (dur > WD) wd_abort = 1'b1;
`endif
    fin_k = (dur == 0) ? 2 : (wd_abort ? WD + 2 : dur + 2);
    for (int k = 1; k <= fin_k; k++) begin
      @(negedge clk);
      check("txn.gnt",   32'(bus.GNT), 32'(oh));
      check("txn.busy",  32'(bus.BUSY), 32'd1);
      check("txn.start", 32'(bus.TMR_START), 32'((k == 1) && (dur != 0)));
      check("txn.done",  32'(bus.DONE), (k == fin_k) ? 32'(oh) : 32'd0);
      check("txn.err",   32'(bus.ERR), 32'((k == fin_k) && wd_abort));
      check("txn.min",   32'(bus.TMR_MIN), 32'(m_min));
      check("txn.sec",   32'(bus.TMR_SEC), 32'(m_sec));
      if (abort_at != 0 && k == abort_at) begin
        rst = 1'b1;
        bus.TMR_TIME_UP = 1'b0;
        return;
      end
      bus.TMR_TIME_UP = ((dur != 0) && !wd_abort && (k == dur + 1)) || (spur && k == 1);
      if (k == 2) begin
        if (drop) cur_req[w] = 1'b0;
        cur_req = cur_req | N'($urandom);
        drive_inputs();
      end
    end
    bus.TMR_TIME_UP = 1'b0;
    m_ptr = (w + 1) % N;
  endtask

  task automatic set_presets(input logic [2:0] mn, input logic [5:0] sc);
    for (int i = 0; i < N; i++) begin
      pm[i] = mn;
      ps[i] = sc;
    end
  endtask

  initial begin
    logic [N-1:0] r;
    rst = 1'b1;
    bus.TMR_TIME_UP = 1'b0;
    set_presets(3'd0, 6'd0);
    cur_req = '0;
    drive_inputs();
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    idle_cycle("post_reset");

    // Single request, preset 0:03
    ps[0] = 6'd3;
    run_txn(4'b0001, 1'b0, 1'b0, 0);
    idle_cycle("t1_idle");

    // Zero preset: no start, DONE two cycles after sampling
    set_presets(3'd0, 6'd0);
    run_txn(4'b0100, 1'b0, 1'b0, 0);
    idle_cycle("t2_idle");

    // All requesting: rotation order from the model
    set_presets(3'd0, 6'd2);
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 1'b0, 1'b0, 0);
      idle_cycle("rr_idle");
    end

    // Seconds clamp 1:63 -> 1:59
    pm[1] = 3'd1;
    ps[1] = 6'd63;
    run_txn(4'b0010, 1'b0, 1'b0, 0);
    idle_cycle("clamp_idle");

    // Long preset, owner drops REQ, stray TIME_UP in LOAD
    set_presets(3'd0, 6'd40);
    run_txn(4'b0001, 1'b1, 1'b1, 0);
    idle_cycle("long_idle");
    idle_gap(3, 1'b1);

    // Move pointer away from 0, then reset mid-RUN with preset 2:00
    set_presets(3'd0, 6'd1);
    run_txn(4'b0010, 1'b0, 1'b0, 0);
    idle_cycle("pre_rst_idle");
    set_presets(3'd2, 6'd0);
    run_txn(4'b0100, 1'b0, 1'b0, 6);
    @(negedge clk);
    m_ptr = 0;
    m_min = '0;
    m_sec = '0;
    check_idle("mid_run_reset");
    rst = 1'b0;
    cur_req = '0;
    drive_inputs();
    idle_cycle("after_reset");
    set_presets(3'd0, 6'd1);
    run_txn(4'b1010, 1'b0, 1'b0, 0);
    idle_cycle("ptr_reset_idle");
    run_txn(4'b1000, 1'b0, 1'b0, 0);
    idle_cycle("req3_idle");

    // Randomized rounds
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        pm[i] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 1)) : 3'd0;
        ps[i] = 6'($urandom_range(0, 63));
      end
      r = ($urandom_range(0, 1) == 0) ? cur_req : N'($urandom);
      if (r == '0) begin
        idle_gap(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        r = N'($urandom_range(1, (1 << N) - 1));
      end
      run_txn(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      idle_cycle("rand_idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
